// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin arbiter feeding a registered set/reset flag bank.
// Optional SR_ARB_LOCK_EN adds REQ_LOCK so a grantee can hold priority.
module sr_flag_arbiter #(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8,
  parameter int IDXW   = 3,
  parameter int GW     = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NREQ-1:0]      REQ_VALID,
  input  logic [NREQ-1:0]      REQ_S,
  input  logic [NREQ-1:0]      REQ_R,
  input  logic [NREQ*IDXW-1:0] REQ_IDX,
`ifdef SR_ARB_LOCK_EN
  input  logic [NREQ-1:0]      REQ_LOCK,
`endif
  output logic [NREQ-1:0]      REQ_READY,
  output logic [NFLAGS-1:0]    Q,
  output logic                 BUSY,
  output logic [GW-1:0]        LAST_GNT
);

  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     last_q;
  logic [GW-1:0]     gidx;
  logic              busy_q;
  logic              cmd_s_q, cmd_r_q;
  logic [IDXW-1:0]   cmd_idx_q;
  logic [NFLAGS-1:0] q_q, q_d;
  logic [NREQ-1:0]   gnt;
  logic              found;
  logic              sel_s, sel_r;
  logic [IDXW-1:0]   sel_idx;
`ifdef SR_ARB_LOCK_EN
  logic              sel_lock;
  logic              lock_q, lock_d;
`endif

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] v);
    return (int'(v) >= NREQ - 1) ? '0 : v + 1'b1;
  endfunction

  // Pass 0 scans from the pointer upward, pass 1 wraps to the low indices.
  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    gidx    = '0;
    sel_s   = 1'b0;
    sel_r   = 1'b0;
    sel_idx = '0;
`ifdef SR_ARB_LOCK_EN
    sel_lock = 1'b0;
`endif
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && REQ_VALID[i] &&
            ((p == 0) == (i >= int'(ptr_q)))) begin
          found   = 1'b1;
          gnt[i]  = 1'b1;
          gidx    = GW'(i);
          sel_s   = REQ_S[i];
          sel_r   = REQ_R[i];
          sel_idx = REQ_IDX[i*IDXW +: IDXW];
`ifdef SR_ARB_LOCK_EN
          sel_lock = REQ_LOCK[i];
`endif
        end
      end
    end
  end

  assign REQ_READY = gnt & {NREQ{RST_N}};

  always_comb begin
    q_d = q_q;
    for (int f = 0; f < NFLAGS; f++) begin
      if (busy_q && (cmd_s_q ^ cmd_r_q) &&
          cmd_idx_q == IDXW'(f))
        q_d[f] = cmd_s_q;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
`ifdef SR_ARB_LOCK_EN
    lock_d = lock_q;
    if (found) begin
      lock_d = sel_lock;
      ptr_d  = sel_lock ? gidx : wrap_inc(gidx);
    end else if (lock_q) begin
      // Lock holder dropped its request: release and move on.
      lock_d = 1'b0;
      ptr_d  = wrap_inc(ptr_q);
    end
`else
    if (found)
      ptr_d = wrap_inc(gidx);
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q       <= '0;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      last_q    <= '0;
      cmd_s_q   <= 1'b0;
      cmd_r_q   <= 1'b0;
      cmd_idx_q <= '0;
    end else begin
      q_q    <= q_d;
      busy_q <= found;
      ptr_q  <= ptr_d;
      if (found) begin
        cmd_s_q   <= sel_s;
        cmd_r_q   <= sel_r;
        cmd_idx_q <= sel_idx;
        last_q    <= gidx;
      end
    end
  end

`ifdef SR_ARB_LOCK_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end
`endif

  assign Q        = q_q;
  assign BUSY     = busy_q;
  assign LAST_GNT = last_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter: directed vectors for sr_flag_arbiter.
// Lock scenario is compiled in only with SR_ARB_LOCK_EN.
module tb_sr_flag_arbiter;
  localparam int NREQ = 4;
  localparam int NFLAGS = 8;
  localparam int IDXW = 4;
  localparam int GW = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  REQ_VALID = '0;
  logic [3:0]  REQ_S = '0;
  logic [3:0]  REQ_R = '0;
  logic [15:0] REQ_IDX = '0;
`ifdef SR_ARB_LOCK_EN
  logic [3:0]  REQ_LOCK = '0;
`endif
  logic [3:0]  REQ_READY;
  logic [7:0]  Q;
  logic        BUSY;
  logic [1:0]  LAST_GNT;

  int n_chk = 0;
  int n_err = 0;

  logic       hs_s [3] = '{1'b1, 1'b0, 1'b0};
  logic       hs_r [3] = '{1'b1, 1'b0, 1'b1};
  logic [3:0] hs_i [3] = '{4'd3, 4'd4, 4'd9};

  always #5 CLK = ~CLK;

  sr_flag_arbiter #(
    .NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW), .GW(GW)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .REQ_VALID(REQ_VALID),
    .REQ_S(REQ_S),
    .REQ_R(REQ_R),
    .REQ_IDX(REQ_IDX),
`ifdef SR_ARB_LOCK_EN
    .REQ_LOCK(REQ_LOCK),
`endif
    .REQ_READY(REQ_READY),
    .Q(Q),
    .BUSY(BUSY),
    .LAST_GNT(LAST_GNT)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic cmd(input int i, input logic s, input logic r,
                     input logic [3:0] idx);
    REQ_VALID[i] = 1'b1;
    REQ_S[i] = s;
    REQ_R[i] = r;
    REQ_IDX[i*4 +: 4] = idx;
  endtask

  task automatic pulse_rst;
    REQ_VALID = '0;
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
  endtask

  initial begin
    REQ_VALID = 4'b0001;
    #3;
    chk("rst_q", 32'(Q), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_last", 32'(LAST_GNT), 32'h0);
    chk("rst_ready", 32'(REQ_READY), 32'h0);
    REQ_VALID = '0;
    RST_N = 1'b1;
    tick();

    cmd(0, 1'b1, 1'b0, 4'd5);
    #1;
    chk("single_ready", 32'(REQ_READY), 32'h1);
    tick();
    REQ_VALID = '0;
    chk("e0_busy", 32'(BUSY), 32'h1);
    chk("e0_q", 32'(Q), 32'h0);
    chk("e0_last", 32'(LAST_GNT), 32'h0);
    tick();
    chk("e1_q", 32'(Q), 32'h20);
    chk("e1_busy", 32'(BUSY), 32'h0);
    REQ_VALID = 4'hF;
    #1;
    chk("ptr_after_single", 32'(REQ_READY), 32'h2);

    pulse_rst();
    chk("rst2_q", 32'(Q), 32'h0);
    for (int i = 0; i < 4; i++) cmd(i, 1'b1, 1'b0, 4'(i));
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_ready%0d", k), 32'(REQ_READY), 32'(1 << k));
      tick();
      REQ_VALID[k] = 1'b0;
      chk($sformatf("rr_last%0d", k), 32'(LAST_GNT), 32'(k));
    end
    chk("rr_q_e4", 32'(Q), 32'h07);
    tick();
    chk("rr_q_e5", 32'(Q), 32'h0F);
    chk("rr_busy_idle", 32'(BUSY), 32'h0);

    pulse_rst();
    REQ_S = '0;
    REQ_R = '0;
    cmd(0, 1'b1, 1'b0, 4'd2);
    tick();
    REQ_VALID = '0;
    cmd(1, 1'b0, 1'b1, 4'd2);
    chk("conf_q_n", 32'(Q), 32'h0);
    tick();
    REQ_VALID = '0;
    chk("conf_q_n1", 32'(Q), 32'h04);
    chk("conf_busy_n1", 32'(BUSY), 32'h1);
    chk("conf_last", 32'(LAST_GNT), 32'h1);
    tick();
    chk("conf_q_n2", 32'(Q), 32'h0);
    chk("conf_busy_n2", 32'(BUSY), 32'h0);

    for (int f = 0; f < 8; f++) begin
      cmd(0, 1'b1, 1'b0, 4'(f));
      tick();
    end
    REQ_VALID = '0;
    tick();
    chk("fill_q", 32'(Q), 32'hFF);
    for (int k = 0; k < 3; k++) begin
      cmd(0, hs_s[k], hs_r[k], hs_i[k]);
      #1;
      chk($sformatf("hold_ready%0d", k), 32'(REQ_READY), 32'h1);
      tick();
      chk($sformatf("hold_busy%0d", k), 32'(BUSY), 32'h1);
      chk($sformatf("hold_q%0d", k), 32'(Q), 32'hFF);
    end
    REQ_VALID = '0;
    tick();
    chk("hold_q_end", 32'(Q), 32'hFF);
    chk("hold_busy_end", 32'(BUSY), 32'h0);

    pulse_rst();
    cmd(0, 1'b1, 1'b0, 4'd7);
    tick();
    REQ_VALID = '0;
    chk("mid_busy_e0", 32'(BUSY), 32'h1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_q", 32'(Q), 32'h0);
    chk("mid_rst_busy", 32'(BUSY), 32'h0);
    RST_N = 1'b1;
    tick();
    tick();
    chk("mid_after_q", 32'(Q), 32'h0);
    chk("mid_after_busy", 32'(BUSY), 32'h0);
    REQ_VALID = 4'hF;
    #1;
    chk("mid_ptr", 32'(REQ_READY), 32'h1);

`ifdef SR_ARB_LOCK_EN
    pulse_rst();
    cmd(1, 1'b1, 1'b0, 4'd1);
    cmd(2, 1'b1, 1'b0, 4'd2);
    REQ_LOCK = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("lock_ready%0d", k), 32'(REQ_READY), 32'h2);
      tick();
      chk($sformatf("lock_last%0d", k), 32'(LAST_GNT), 32'h1);
    end
    REQ_LOCK = '0;
    #1;
    chk("unlock_ready", 32'(REQ_READY), 32'h2);
    tick();
    #1;
    chk("after_unlock_ready", 32'(REQ_READY), 32'h4);
    tick();
    chk("after_unlock_last", 32'(LAST_GNT), 32'h2);
    REQ_VALID = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
